// File: rtl/klein_pkg.sv
// Shared types, constants and GF(2^8) helper for the KLEIN MixNibbles datapath.
// Column 0 occupies the upper half of the 64-bit state; byte a0 is the MSB of a column.
package klein_pkg;

    localparam logic [7:0] RED_POLY_DEF = 8'h1b;

    localparam int STATE_W       = 64;
    localparam int COL_W         = 32;
    localparam int BYTE_W        = 8;
    localparam int BYTES_PER_COL = 4;
    localparam int COL0_MSB      = 63;
    localparam int COL1_MSB      = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COL0 = 2'd1,
        COL1 = 2'd2,
        DONE = 2'd3
    } state_e;

    // Multiply by x in GF(2^8), reducing by the given low polynomial byte.
    function automatic logic [7:0] xtime(input logic [7:0] x, input logic [7:0] poly);
        return {x[6:0], 1'b0} ^ (x[7] ? poly : 8'h00);
    endfunction

endpackage

// File: rtl/klein_mix_col_comb.sv
// Combinational forward mix of one 32-bit column: r_i = 2a_i ^ 3a_{i+1} ^ a_{i+2} ^ a_{i+3}.
module klein_mix_col_comb
    import klein_pkg::*;
#(
    parameter logic [7:0] RED_POLY = RED_POLY_DEF
) (
    input  logic [COL_W-1:0] col_i,
    output logic [COL_W-1:0] col_o
);

    logic [BYTES_PER_COL-1:0][BYTE_W-1:0] a;
    logic [BYTES_PER_COL-1:0][BYTE_W-1:0] a2;
    logic [BYTES_PER_COL-1:0][BYTE_W-1:0] r;

    // Packed index 3 holds a0 so the column maps straight onto the bus.
    assign a = col_i;

    for (genvar i = 0; i < BYTES_PER_COL; i++) begin : g_byte
        assign a2[i] = xtime(a[i], RED_POLY);
    end

    // Row k (a_k at packed index 3-k) is circulant over the four input bytes.
    for (genvar k = 0; k < BYTES_PER_COL; k++) begin : g_row
        localparam int P0 = 3 - k;
        localparam int P1 = 3 - ((k + 1) % 4);
        localparam int P2 = 3 - ((k + 2) % 4);
        localparam int P3 = 3 - ((k + 3) % 4);
        assign r[P0] = a2[P0] ^ (a2[P1] ^ a[P1]) ^ a[P2] ^ a[P3];
    end

    assign col_o = r;

endmodule

// File: rtl/klein_mix_cols_seq.sv
// Sequential forward MixNibbles: one shared column multiplier, one column per clock,
// valid/ready on both sides, three cycles per block when streaming.
module klein_mix_cols_seq
    import klein_pkg::*;
#(
    parameter logic [7:0] RED_POLY = RED_POLY_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [STATE_W-1:0] cap_q, cap_d;
    logic [STATE_W-1:0] out_q, out_d;
    logic [COL_W-1:0]   col_in, col_out;

    klein_mix_col_comb #(.RED_POLY(RED_POLY)) u_mix (
        .col_i (col_in),
        .col_o (col_out)
    );

    always_comb begin
        state_d   = state_q;
        cap_d     = cap_q;
        out_d     = out_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        col_in    = cap_q[COL0_MSB -: COL_W];
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cap_d   = in_data;
                    state_d = COL0;
                end
            end
            COL0: begin
                busy                     = 1'b1;
                col_in                   = cap_q[COL0_MSB -: COL_W];
                out_d[COL0_MSB -: COL_W] = col_out;
                state_d                  = COL1;
            end
            COL1: begin
                busy                     = 1'b1;
                col_in                   = cap_q[COL1_MSB -: COL_W];
                out_d[COL1_MSB -: COL_W] = col_out;
                state_d                  = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                // Result stays put until downstream takes it; a waiting input is ignored.
                if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        cap_d   = in_data;
                        state_d = COL0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cap_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            out_q   <= out_d;
        end
    end

    assign out_data = out_q;

endmodule

// File: tb/tb_klein_mix_cols_seq.sv
// Directed + streaming bench for klein_mix_cols_seq against a matrix-product GF(2^8) model.
module tb_klein_mix_cols_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [63:0] in_q[$];
    bit          b2b_phase = 1'b0;
    int          last_out_cyc = -1;

    logic [7:0] fwd_c [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
    logic [7:0] inv_c [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

    klein_mix_cols_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Generic GF(2^8) multiply, poly 0x11b.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // Circulant matrix product on both columns; inv selects the inverse coefficients.
    function automatic logic [63:0] mat_mix(input logic [63:0] s, input bit inv);
        logic [63:0] res = 64'h0;
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 4; r++) begin
                logic [7:0] acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    logic [7:0] aj   = s[63 - 32*c - 8*j -: 8];
                    logic [7:0] coef = inv ? inv_c[(j - r + 4) % 4] : fwd_c[(j - r + 4) % 4];
                    acc = acc ^ gmul(coef, aj);
                end
                res[63 - 32*c - 8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output monitor: every valid cycle compared against the oldest accepted input.
    always @(negedge clk) begin
        if (rst) begin
            in_q.delete();
        end else begin
            if (out_valid) begin
                if (in_q.size() == 0) begin
                    chk("unexpected_out_valid", 64'h1, 64'h0);
                end else begin
                    chk("mon_out_data", out_data, mat_mix(in_q[0], 1'b0));
                    if (out_ready) begin
                        chk("mon_roundtrip", mat_mix(out_data, 1'b1), in_q[0]);
                        if (b2b_phase && last_out_cyc >= 0)
                            chk("b2b_spacing", 64'(cyc - last_out_cyc), 64'd3);
                        last_out_cyc = cyc;
                        void'(in_q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) in_q.push_back(in_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_in_ready(input string name);
        int budget = 10;
        while (!in_ready && budget > 0) begin
            step();
            budget--;
        end
        if (!in_ready) chk({name, "_timeout"}, 64'h0, 64'h1);
    endtask

    // Accept one block from IDLE and check the exact 2-cycle latency.
    task automatic run_block(input string name, input logic [63:0] din, input logic [63:0] exp);
        in_valid = 1'b1;
        in_data  = din;
        wait_in_ready(name);
        step();                                   // E0: accept
        in_valid = 1'b0;
        in_data  = ~din;                          // must not affect the result
        chk({name, "_busy_e0"}, 64'(busy), 64'h1);
        chk({name, "_ov_e0"}, 64'(out_valid), 64'h0);
        step();                                   // E1
        chk({name, "_ov_e1"}, 64'(out_valid), 64'h0);
        step();                                   // E2
        chk({name, "_ov_e2"}, 64'(out_valid), 64'h1);
        chk({name, "_data"}, out_data, exp);
    endtask

    initial begin
        logic [63:0] blkA, blkB, blk;
        int budget;

        rst = 1'b1; in_valid = 1'b0; in_data = 64'h0; out_ready = 1'b1;
        step(); step();
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_out_data", out_data, 64'h0);
        rst = 1'b0;
        step();

        // Pin the model to known MixColumns vectors.
        chk("model_kv", mat_mix(64'hdb135345f20a225c, 1'b0), 64'h8e4da1bc9fdc589d);
        chk("model_fixed", mat_mix(64'h01010101c6c6c6c6, 1'b0), 64'h01010101c6c6c6c6);
        chk("model_carry", mat_mix(64'hd4d4d4d52d26314c, 1'b0), 64'hd5d5d7d64d7ebdf8);
        chk("model_inv", mat_mix(64'h8e4da1bc9fdc589d, 1'b1), 64'hdb135345f20a225c);

        run_block("kv", 64'hdb135345f20a225c, 64'h8e4da1bc9fdc589d);
        step();
        run_block("fixed", 64'h01010101c6c6c6c6, 64'h01010101c6c6c6c6);
        step();
        run_block("carry", 64'hd4d4d4d52d26314c, 64'hd5d5d7d64d7ebdf8);
        step();

        // Backpressure: result held, new input refused until out_ready returns.
        blkA = 64'h0123456789abcdef;
        blkB = 64'hfedcba9876543210;
        out_ready = 1'b0;
        run_block("bpA", blkA, mat_mix(blkA, 1'b0));
        in_valid = 1'b1;
        in_data  = blkB;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_in_ready", 64'(in_ready), 64'h0);
            chk("bp_out_valid", 64'(out_valid), 64'h1);
            chk("bp_hold", out_data, mat_mix(blkA, 1'b0));
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'h1);
        step();                                   // accepts B
        in_valid = 1'b0;
        chk("bp_B_ov_e0", 64'(out_valid), 64'h0);
        step();
        step();
        chk("bp_B_ov_e2", 64'(out_valid), 64'h1);
        chk("bp_B_data", out_data, mat_mix(blkB, 1'b0));
        step();

        // Reset during COL1 discards the block.
        in_valid = 1'b1;
        in_data  = 64'h1122334455667788;
        step();                                   // accept -> COL0
        in_valid = 1'b0;
        step();                                   // -> COL1
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'h0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'h1);
        chk("mid_rst_out_data", out_data, 64'h0);
        step();
        rst = 1'b0;
        step();
        run_block("post_rst", 64'hdb135345f20a225c, 64'h8e4da1bc9fdc589d);
        step();

        // Streaming with both handshakes held high.
        b2b_phase    = 1'b1;
        last_out_cyc = -1;
        for (int k = 0; k < 100; k++) begin
            blk      = {$urandom(), $urandom()};
            in_valid = 1'b1;
            in_data  = blk;
            wait_in_ready("b2b");
            step();
        end
        in_valid = 1'b0;
        budget = 20;
        while (in_q.size() != 0 && budget > 0) begin
            step();
            budget--;
        end
        chk("drain_empty", 64'(in_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/klein_mix_cols_seq.md
Name: klein_mix_cols_seq

Overview:
- Forward MixNibbles (AES-style MixColumns over GF(2^8), polynomial 0x11b) for the KLEIN encryption datapath.
- Processes the 64-bit state as two 32-bit columns, one column per clock, through a single shared column multiplier.
- Uses a valid/ready handshake on both sides.
- Counterpart of the decryption-side inverse MixNibbles; sits between RotateNibbles and the next round's AddRoundKey.

Parameters:
- RED_POLY, 8'h1b, low byte of the GF(2^8) reduction polynomial used by xtime.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  64  state; column 0 = [63:32], column 1 = [31:0]; byte a0 is the MSB of each column.
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  64  mixed state, same byte layout as in_data.
- busy  output  1  high in COL0 or COL1.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=64'h0, input capture register=0. Reset takes effect immediately; it may be asserted mid-operation and discards any in-flight data.
- Column math, per column a0..a3:
  - r0 = 2a0^3a1^a2^a3
  - r1 = a0^2a1^3a2^a3
  - r2 = a0^a1^2a2^3a3
  - r3 = 3a0^a1^a2^2a3
  - 2x = xtime(x) = {x[6:0],0} ^ (x[7] ? RED_POLY : 0)
  - 3x = xtime(x)^x
  - All arithmetic is 8-bit XOR; no carries.
- FSM states: IDLE, COL0, COL1, DONE.
  - IDLE: in_ready=1. When in_valid, capture in_data and go to COL0.
  - COL0: out_data[63:32] <= mix(capture[63:32]); go to COL1.
  - COL1: out_data[31:0] <= mix(capture[31:0]); go to DONE.
  - DONE: out_valid=1.
    - out_ready=1 and in_valid=1: capture new in_data, go to COL0 (back-to-back).
    - out_ready=1 and in_valid=0: go to IDLE.
    - out_ready=0: hold.
- in_ready = (state==IDLE) | (state==DONE & out_ready). in_ready is combinational from state and out_ready only; it never depends on in_valid.
- Latency: handshake at edge E0 gives out_valid high after edge E2. Throughput is one block per 3 cycles in back-to-back operation.
- Stability while out_valid=1 and out_ready=0: out_data and out_valid are held, and in_valid is ignored.
- out_data stays stable from DONE until the next COL0 edge. A partially updated out_data during COL0/COL1 is permitted because out_valid=0 there.
- in_data is sampled only on the accepting edge; later changes do not affect the result.

Decomposition:
- Package klein_pkg holds:
  - RED_POLY default constant.
  - xtime function.
  - FSM state enum (IDLE/COL0/COL1/DONE, 2-bit).
  - Column/byte slice constants.
- Sub-module klein_mix_col_comb: purely combinational, 32-bit column in, 32-bit column out, instantiated once. The FSM muxes capture[63:32] or capture[31:0] into it.

Test Plan:
- Reset mid-operation: pulse rst while in COL1 -> immediately out_valid=0, in_ready=1, out_data=0; the next accepted block produces the correct result.
- Known vector: in_data=64'hdb135345f20a225c, out_ready=1 -> out_valid high 2 cycles after acceptance, out_data=64'h8e4da1bc9fdc589d.
- Fixed points and carry paths:
  - 64'h01010101c6c6c6c6 -> 64'h01010101c6c6c6c6.
  - 64'hd4d4d4d52d26314c -> 64'hd5d5d7d64d7ebdf8.
- Backpressure: out_ready=0 for 5 cycles after DONE while in_valid=1 with different data -> in_ready=0, out_data unchanged; out_ready=1 -> new block accepted on the same edge, and its result appears 2 cycles later.
- Back-to-back: 100 random blocks with in_valid and out_ready held high -> one result every 3 cycles, each matching a golden model. Round-trip through the decryption-side inverse MixNibbles returns the original state.
